// File: rtl/reg_xfer_bank.sv
// reg_xfer_bank: bank of NREG registers, WIDTH bits each, driven by a
// valid/ready command interface. Single-cycle LOAD/MOVE/ADD/CLR/SHL/SHR/NOP;
// SWAP runs over three edges through an internal temp register.
module reg_xfer_bank #(
    parameter int WIDTH = 4,
    parameter int NREG  = 4,
    localparam int AW   = (NREG <= 2) ? 1 : $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_src,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [AW-1:0]    rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             carry
);
    localparam logic [AW:0] LP_NREG = (AW+1)'(NREG);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_MOVE = 3'd2;
    localparam logic [2:0] OP_SWAP = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_SHR  = 3'd7;

    typedef enum logic [1:0] {IDLE, SWAP_A, SWAP_B} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_regs [NREG];
    logic [WIDTH-1:0] r_tmp;
    logic [AW-1:0]    r_src;
    logic [AW-1:0]    r_dst;
    logic             r_carry;
    logic             r_done;
    logic             r_err;

    state_t           w_next;
    logic             w_accept;
    logic             w_ok;
    logic [AW-1:0]    w_sel_src;
    logic [AW-1:0]    w_sel_dst;
    logic [WIDTH-1:0] w_src_val;
    logic [WIDTH-1:0] w_dst_val;
    logic [WIDTH:0]   w_sum;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_idx;
    logic [WIDTH-1:0] w_wr_val;
    logic             w_carry_en;
    logic             w_tmp_en;
    logic             w_done_n;
    logic             w_err_n;

    assign cmd_ready = (r_state == IDLE) & ~rst;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign carry     = r_carry;
    assign w_accept  = cmd_valid & cmd_ready;

    // In IDLE operands come from the command; during a swap from the latched indices.
    assign w_sel_src = (r_state == IDLE) ? cmd_src : r_src;
    assign w_sel_dst = (r_state == IDLE) ? cmd_dst : r_dst;
    assign w_sum     = {1'b0, w_dst_val} + {1'b0, w_src_val};

    // Operand and read-port muxes; unmatched (out-of-range) indices read as 0.
    always_comb begin
        w_src_val = '0;
        w_dst_val = '0;
        rd_data   = '0;
        for (int i = 0; i < NREG; i++) begin
            if (w_sel_src == AW'(i)) w_src_val = r_regs[i];
            if (w_sel_dst == AW'(i)) w_dst_val = r_regs[i];
            if (rd_sel == AW'(i))    rd_data   = r_regs[i];
        end
    end

    // Range check: dst for every op but NOP, src too for MOVE/SWAP/ADD.
    always_comb begin
        w_ok = 1'b1;
        if (cmd_op != OP_NOP) begin
            if ({1'b0, cmd_dst} >= LP_NREG) w_ok = 1'b0;
            if ((cmd_op == OP_MOVE || cmd_op == OP_SWAP || cmd_op == OP_ADD) &&
                ({1'b0, cmd_src} >= LP_NREG)) w_ok = 1'b0;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_next     = r_state;
        w_wr_en    = 1'b0;
        w_wr_idx   = w_sel_dst;
        w_wr_val   = '0;
        w_carry_en = 1'b0;
        w_tmp_en   = 1'b0;
        w_done_n   = 1'b0;
        w_err_n    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!w_ok) begin
                        w_err_n = 1'b1;
                    end else begin
                        w_done_n = (cmd_op != OP_SWAP);
                        case (cmd_op)
                            OP_LOAD: begin w_wr_en = 1'b1; w_wr_val = cmd_data; end
                            OP_MOVE: begin w_wr_en = 1'b1; w_wr_val = w_src_val; end
                            OP_SWAP: begin w_tmp_en = 1'b1; w_next = SWAP_A; end
                            OP_ADD: begin
                                w_wr_en    = 1'b1;
                                w_wr_val   = w_sum[WIDTH-1:0];
                                w_carry_en = 1'b1;
                            end
                            OP_CLR:  begin w_wr_en = 1'b1; w_wr_val = '0; end
                            OP_SHL:  begin w_wr_en = 1'b1; w_wr_val = w_dst_val << 1; end
                            OP_SHR:  begin w_wr_en = 1'b1; w_wr_val = w_dst_val >> 1; end
                            default: ;
                        endcase
                    end
                end
            end
            SWAP_A: begin
                w_wr_en  = 1'b1;
                w_wr_idx = r_src;
                w_wr_val = w_dst_val;
                w_next   = SWAP_B;
            end
            SWAP_B: begin
                w_wr_en  = 1'b1;
                w_wr_idx = r_dst;
                w_wr_val = r_tmp;
                w_done_n = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State, register bank, temp, carry and status pulses; reset aborts any swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tmp   <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_n;
            r_err   <= w_err_n;
            if (w_tmp_en) begin
                r_tmp <= w_src_val;
                r_src <= cmd_src;
                r_dst <= cmd_dst;
            end
            if (w_carry_en) r_carry <= w_sum[WIDTH];
            for (int i = 0; i < NREG; i++) begin
                if (w_wr_en && (w_wr_idx == AW'(i))) r_regs[i] <= w_wr_val;
            end
        end
    end
endmodule

// File: tb/tb_reg_xfer_bank.sv
// Directed testbench for reg_xfer_bank: a NREG=4 instance for the main
// operations and a NREG=3 instance for the index range check.
module tb_reg_xfer_bank;
    logic       clk = 1'b0;
    logic       rst;
    // NREG=4 instance
    logic       cmd_valid, cmd_ready, busy, done, err, carry;
    logic [2:0] cmd_op;
    logic [1:0] cmd_src, cmd_dst, rd_sel;
    logic [3:0] cmd_data, rd_data;
    // NREG=3 instance
    logic       c3_valid, c3_ready, c3_busy, c3_done, c3_err, c3_carry;
    logic [2:0] c3_op;
    logic [1:0] c3_src, c3_dst, c3_rd_sel;
    logic [3:0] c3_data, c3_rd_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_xfer_bank #(.WIDTH(4), .NREG(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_data(cmd_data),
        .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
        .carry(carry)
    );

    reg_xfer_bank #(.WIDTH(4), .NREG(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
        .cmd_op(c3_op), .cmd_src(c3_src), .cmd_dst(c3_dst), .cmd_data(c3_data),
        .rd_sel(c3_rd_sel), .rd_data(c3_rd_data), .busy(c3_busy), .done(c3_done),
        .err(c3_err), .carry(c3_carry)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [1:0] src, input logic [1:0] dst,
                       input logic [3:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_data  = data;
    endtask

    task automatic rd(input logic [1:0] sel, input logic [3:0] exp, input string tag);
        rd_sel = sel;
        #1;
        chk(tag, rd_data, exp);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0; cmd_data = '0; rd_sel = '0;
        c3_valid = 1'b0; c3_op = '0; c3_src = '0; c3_dst = '0; c3_data = '0; c3_rd_sel = '0;
        step(); step();
        rst = 1'b0;
        #1;

        // Reset state
        for (int i = 0; i < 4; i++) rd(2'(i), 4'h0, "rst_rd");
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_carry", carry, 0);

        // LOAD, LOAD, MOVE back to back
        cmd(3'd1, 2'd0, 2'd0, 4'h5); step(); chk("ld0_done", done, 1);
        cmd(3'd1, 2'd0, 2'd1, 4'h9); step(); chk("ld1_done", done, 1);
        cmd(3'd2, 2'd1, 2'd2, 4'h0); step(); chk("mov_done", done, 1);
        cmd_valid = 1'b0; step(); chk("idle_done", done, 0);
        rd(2'd2, 4'h9, "mov_r2");
        rd(2'd1, 4'h9, "mov_r1");
        rd(2'd0, 4'h5, "ld_r0");

        // SWAP R0,R1 held valid: two busy cycles, then a second swap
        cmd(3'd3, 2'd0, 2'd1, 4'h0);
        chk("sw_ready0", cmd_ready, 1);
        step();
        chk("sw_a_ready", cmd_ready, 0); chk("sw_a_busy", busy, 1); chk("sw_a_done", done, 0);
        rd(2'd0, 4'h5, "sw_a_r0");
        step();
        chk("sw_b_ready", cmd_ready, 0); chk("sw_b_done", done, 0);
        rd(2'd0, 4'h9, "sw_b_r0");
        step();
        chk("sw_end_done", done, 1); chk("sw_end_ready", cmd_ready, 1);
        rd(2'd0, 4'h9, "sw_r0"); rd(2'd1, 4'h5, "sw_r1");
        step();
        chk("sw2_busy", busy, 1); chk("sw2_done", done, 0);
        cmd_valid = 1'b0;
        step(); step();
        chk("sw2_end_done", done, 1);
        rd(2'd0, 4'h5, "sw2_r0"); rd(2'd1, 4'h9, "sw2_r1");

        // SWAP with src==dst leaves contents unchanged
        cmd(3'd3, 2'd2, 2'd2, 4'h0); step(); cmd_valid = 1'b0; step(); step();
        chk("swself_done", done, 1);
        rd(2'd2, 4'h9, "swself_r2");

        // ADD with carry, shifts, carry hold, doubling
        cmd(3'd1, 2'd0, 2'd3, 4'hA); step();
        cmd(3'd4, 2'd3, 2'd2, 4'h0); step();
        chk("add_carry", carry, 1); chk("add_done", done, 1);
        rd(2'd2, 4'h3, "add_r2");
        cmd(3'd6, 2'd0, 2'd2, 4'h0); step(); rd(2'd2, 4'h6, "shl_r2");
        cmd(3'd7, 2'd0, 2'd2, 4'h0); step(); rd(2'd2, 4'h3, "shr_r2");
        chk("shift_carry", carry, 1);
        cmd(3'd4, 2'd2, 2'd2, 4'h0); step();
        rd(2'd2, 4'h6, "dbl_r2"); chk("dbl_carry", carry, 0);
        cmd(3'd7, 2'd0, 2'd3, 4'h0); step(); rd(2'd3, 4'h5, "shr_r3");
        cmd(3'd5, 2'd0, 2'd3, 4'h0); step(); rd(2'd3, 4'h0, "clr_r3");
        cmd(3'd0, 2'd0, 2'd0, 4'h0); step();
        chk("nop_done", done, 1); chk("nop_err", err, 0);
        rd(2'd0, 4'h5, "nop_r0");
        cmd_valid = 1'b0; step();

        // Reset during SWAP_A aborts the swap
        cmd(3'd3, 2'd0, 2'd1, 4'h0); step();
        chk("rsw_busy", busy, 1);
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1; chk("rsw_ready_in_rst", cmd_ready, 0);
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) rd(2'(i), 4'h0, "rsw_rd");
        chk("rsw_ready", cmd_ready, 1); chk("rsw_busy2", busy, 0);
        chk("rsw_done", done, 0); chk("rsw_carry", carry, 0);
        step();
        chk("rsw_done2", done, 0);

        // NREG=3: out-of-range dst and src are rejected
        c3_valid = 1'b1; c3_op = 3'd1; c3_dst = 2'd2; c3_data = 4'h6; step();
        chk("n3_ld_done", c3_done, 1);
        c3_dst = 2'd3; c3_data = 4'h7; step();
        chk("n3_bad_err", c3_err, 1); chk("n3_bad_done", c3_done, 0);
        c3_op = 3'd2; c3_src = 2'd3; c3_dst = 2'd0; step();
        chk("n3_badsrc_err", c3_err, 1);
        c3_valid = 1'b0; step();
        chk("n3_err_clr", c3_err, 0); chk("n3_ready", c3_ready, 1);
        c3_rd_sel = 2'd2; #1; chk("n3_r2", c3_rd_data, 4'h6);
        c3_rd_sel = 2'd0; #1; chk("n3_r0", c3_rd_data, 4'h0);
        c3_rd_sel = 2'd3; #1; chk("n3_r3", c3_rd_data, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_xfer_bank.md
Name: reg_xfer_bank

Overview:
- Parametrised successor to the single 4-bit load register: a bank of NREG registers, each WIDTH bits wide.
- Register-transfer operations run under a valid/ready command handshake: load, move, swap, add, clear and shift.
- Swap is a multi-cycle operation through an internal temp register, controlled by a small FSM.
- Sits as the datapath register stage of the register-transfer labs, driven by a controller or by switches and debounced buttons.

Parameters:
- WIDTH, 4, bits per register (≥1).
- NREG, 4, number of registers (≥2). Index width AW = max(1, ceil(log2(NREG))), derived as a localparam.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bank can accept a command this cycle.
- cmd_op  in  3  operation code, listed under Behaviour.
- cmd_src  in  AW  source register index.
- cmd_dst  in  AW  destination register index.
- cmd_data  in  WIDTH  immediate data for LOAD.
- rd_sel  in  AW  read-port index.
- rd_data  out  WIDTH  combinational R[rd_sel]; 0 if rd_sel ≥ NREG.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse, the cycle after a command's final register write.
- err  out  1  one-cycle pulse, the cycle after a rejected command.
- carry  out  1  carry out of the most recent ADD.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all R[i], TMP and carry cleared to 0.
  - FSM goes to IDLE.
  - done=0, err=0.
  - Overrides any command, including a swap in progress, which is aborted.
- Command acceptance:
  - A command is accepted when cmd_valid & cmd_ready at a rising edge.
  - cmd_ready = (state==IDLE) & ~rst.
  - busy = (state!=IDLE).
  - Inputs are sampled only at acceptance; changes to cmd_* while busy are ignored.
- Opcodes (all results modulo 2^WIDTH):
  - 0 NOP: no write; done pulses.
  - 1 LOAD: R[dst]<=cmd_data.
  - 2 MOVE: R[dst]<=R[src], using the old value of src.
  - 3 SWAP: multi-cycle, see FSM.
  - 4 ADD: R[dst]<=R[dst]+R[src]; carry<=bit WIDTH of the (WIDTH+1)-bit sum. If src==dst, the register is doubled.
  - 5 CLR: R[dst]<=0.
  - 6 SHL: R[dst]<={R[dst][WIDTH-2:0],1'b0}; for WIDTH=1, the result is 0.
  - 7 SHR: R[dst]<={1'b0,R[dst][WIDTH-1:1]}.
- Single-cycle ops (everything except SWAP): the write happens at the acceptance edge; done=1 for the following cycle only. Back-to-back commands can be accepted every cycle.
- carry changes only on ADD; all other ops hold it.
- Range check:
  - A command is rejected if any index it uses is ≥ NREG: dst for all ops except NOP; src as well for MOVE, SWAP and ADD.
  - On rejection there is no write and no carry change; err=1 for the next cycle and done stays 0. The FSM stays IDLE.
- FSM for SWAP (states IDLE, SWAP_A, SWAP_B):
  - Acceptance edge: TMP<=R[src]; latch src and dst; go to SWAP_A.
  - SWAP_A edge: R[src]<=R[dst]; go to SWAP_B.
  - SWAP_B edge: R[dst]<=TMP; go to IDLE.
  - done=1 the cycle after the SWAP_B edge, which is also the first cycle in which cmd_ready=1 again.
  - cmd_ready=0 for the two busy cycles.
  - src==dst: the same three-cycle sequence runs and contents are unchanged.
- Read port:
  - purely combinational.
  - Reflects a write in the cycle after the edge.
  - rd_data shows intermediate values during a swap, e.g. R[src] already updated in SWAP_B.
- done and err are never both 1.

Test Plan:
- Reset, then read all registers → each read gives 0; cmd_ready=1, busy=0, done=0, carry=0.
- LOAD R0=5, R1=9, then MOVE src1→dst2 → R2=9 and R1=9; done pulses once per command across 3 consecutive accepted cycles.
- With R0=5, R1=9, SWAP src0,dst1 held valid for 4 cycles → cmd_ready low for 2 cycles; R0=9, R1=5; done once; the second swap is accepted only when ready returns.
- R2=9, R3=0xA, ADD dst2 src3 → R2=0x3, carry=1; then SHL R2 → 0x6; then SHR R2 → 0x3; carry stays 1.
- NREG=3 instance, LOAD dst=3 data=7 → err pulses 1 cycle, no register changes, done=0.
- Assert rst in SWAP_A → next cycle all registers 0, state IDLE, cmd_ready=1, no done pulse.
